// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, row count and S-box tables.
// The inverse S-box exists only when SUB_SHIFT_DECRYPT_EN is defined.
package aes_pkg;

  localparam int AES_ROWS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUB_SHIFT_DECRYPT_EN
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

  // Rotate a row left by n byte positions; column 0 lives in bits [31:24].
  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    case (n)
      2'd1:    r = {w[23:0], w[31:24]};
      2'd2:    r = {w[15:0], w[31:16]};
      2'd3:    r = {w[7:0],  w[31:8]};
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit S-box lookup. With SUB_SHIFT_DECRYPT_EN defined an
// inv select chooses the inverse table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] val,
`ifdef SUB_SHIFT_DECRYPT_EN
  input  logic       inv,
`endif
  output logic [7:0] res
);

  // Table lookup; inverse table overrides only when selected.
  always_comb begin
    res = SBOX[val];
`ifdef SUB_SHIFT_DECRYPT_EN
    if (inv) res = INV_SBOX[val];
`endif
  end

endmodule

// File: rtl/sub_shift_rows.sv
// Iterative SubBytes + ShiftRows: one state row per cycle through four
// S-boxes, then the row is rotated by its index and written back in place.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds valid and data stable until that edge.
// Optional macro SUB_SHIFT_DECRYPT_EN adds a decrypt input selecting the
// inverse S-box and right rotation for the whole block.
module sub_shift_rows
  import aes_pkg::*;
#(
  parameter int ROWS  = AES_ROWS,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
`ifdef SUB_SHIFT_DECRYPT_EN
  input  logic        decrypt,
`endif
  input  logic [31:0] line0,
  input  logic [31:0] line1,
  input  logic [31:0] line2,
  input  logic [31:0] line3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] outline0,
  output logic [31:0] outline1,
  output logic [31:0] outline2,
  output logic [31:0] outline3,
  output logic        busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rows_q [ROWS];
  logic [31:0]       cur_row;
  logic [31:0]       sub_word;
  logic [31:0]       new_row;
`ifdef SUB_SHIFT_DECRYPT_EN
  logic              inv_q;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: accept in IDLE, four row cycles in SUB, hold in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)      state_d = SUB;
      SUB:     if (cnt_q == LAST) state_d = DONE;
      DONE:    if (out_ready)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cur_row = rows_q[cnt_q];

  // Four S-boxes, one per column byte of the active row.
  for (genvar c = 0; c < 4; c++) begin : g_sbox
    aes_sbox u_sbox (
      .val (cur_row[31-8*c -: 8]),
`ifdef SUB_SHIFT_DECRYPT_EN
      .inv (inv_q),
`endif
      .res (sub_word[31-8*c -: 8])
    );
  end

  // Row r rotates left by r bytes (right by r when decrypting).
  always_comb begin
    new_row = rotl_bytes(sub_word, 2'(cnt_q));
`ifdef SUB_SHIFT_DECRYPT_EN
    if (inv_q) new_row = rotl_bytes(sub_word, 2'd0 - 2'(cnt_q));
`endif
  end

  // Datapath: capture on acceptance, rewrite one row per SUB cycle; the
  // counter parks on the last row and only clears on leaving DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int r = 0; r < ROWS; r++) rows_q[r] <= '0;
`ifdef SUB_SHIFT_DECRYPT_EN
      inv_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            rows_q[0] <= line0;
            rows_q[1] <= line1;
            rows_q[2] <= line2;
            rows_q[3] <= line3;
            cnt_q     <= '0;
`ifdef SUB_SHIFT_DECRYPT_EN
            inv_q     <= decrypt;
`endif
          end
        end
        SUB: begin
          rows_q[cnt_q] <= new_row;
          if (cnt_q != LAST) cnt_q <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          if (out_ready) cnt_q <= '0;
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Status outputs decode straight from the state register; in_ready is
  // held low while reset is asserted.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  assign outline0 = rows_q[0];
  assign outline1 = rows_q[1];
  assign outline2 = rows_q[2];
  assign outline3 = rows_q[3];

endmodule

// File: tb/tb_sub_shift_rows.sv
// Directed bench for sub_shift_rows: reset, FIPS-197 round-1 vectors,
// MixColumns chaining, backpressure, rotation boundaries, mid-block reset.
// Decrypt vectors are compiled in with SUB_SHIFT_DECRYPT_EN.
module tb_sub_shift_rows;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        dec_drv;
  logic [31:0] line0, line1, line2, line3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] outline0, outline1, outline2, outline3;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  sub_shift_rows dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SUB_SHIFT_DECRYPT_EN
    .decrypt   (dec_drv),
`endif
    .line0     (line0),
    .line1     (line1),
    .line2     (line2),
    .line3     (line3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outline0  (outline0),
    .outline1  (outline1),
    .outline2  (outline2),
    .outline3  (outline3),
    .busy      (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_rows(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
    check({tag, "_o0"}, outline0, e0);
    check({tag, "_o1"}, outline1, e1);
    check({tag, "_o2"}, outline2, e2);
    check({tag, "_o3"}, outline3, e3);
  endtask

  task automatic check_idle_zero(input string tag, input logic rdy);
    check({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_iready"}, 32'(in_ready),  32'(rdy));
    check_rows(tag, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Driver: wait (bounded) for in_ready, present one state for one edge.
  task automatic send(input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] r3, input logic dec);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    line0 = r0; line1 = r1; line2 = r2; line3 = r3;
    dec_drv  = dec;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency: out_valid low after E3, high after E4 (E0 = acceptance).
  task automatic wait_done(input string tag);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_lat_e3"}, 32'(out_valid), 32'd0);
    check({tag, "_busy_e3"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, "_lat_e4"}, 32'(out_valid), 32'd1);
    check({tag, "_iready_done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference MixColumns applied to the observed outputs.
  task automatic check_mix(input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] m0, m1, m2, m3;
    logic [7:0]  a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = outline0[31-8*c -: 8];
      a1 = outline1[31-8*c -: 8];
      a2 = outline2[31-8*c -: 8];
      a3 = outline3[31-8*c -: 8];
      m0[31-8*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      m1[31-8*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      m2[31-8*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      m3[31-8*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    check("mix_r0", m0, e0);
    check("mix_r1", m1, e1);
    check("mix_r2", m2, e2);
    check("mix_r3", m3, e3);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dec_drv = 1'b0;
    line0 = '0; line1 = '0; line2 = '0; line3 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("rst_hold", 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("rst_rel", 1'b1);

    // FIPS-197 round 1 with backpressure and ignored in_valid pulses.
    send(32'h19a09ae9, 32'h3df4c6f8, 32'he3e28d48, 32'hbe2b2a08, 1'b0);
    wait_done("fips");
    check_rows("fips", 32'hd4e0b81e, 32'hbfb44127, 32'h5d521198, 32'h30aef1e5);
    check_mix(32'h04e04828, 32'h66cbf806, 32'h8119d326, 32'he59a7a4c);
    line0 = 32'hdeadbeef; line1 = 32'h01234567; line2 = 32'h89abcdef; line3 = 32'hcafef00d;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      @(posedge clk); #1;
      check("bp_ovalid", 32'(out_valid), 32'd1);
      check("bp_iready", 32'(in_ready), 32'd0);
      check_rows("bp", 32'hd4e0b81e, 32'hbfb44127, 32'h5d521198, 32'h30aef1e5);
    end
    in_valid = 1'b0;
    drain();
    check("bp_rel_ovalid", 32'(out_valid), 32'd0);
    check("bp_rel_iready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp_rel_busy", 32'(busy), 32'd0);

    // All zero, out_ready held high: DONE lasts exactly one cycle.
    out_ready = 1'b1;
    send(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    wait_done("zero");
    check_rows("zero", 32'h63636363, 32'h63636363, 32'h63636363, 32'h63636363);
    @(posedge clk); #1;
    check("zero_one_cycle", 32'(out_valid), 32'd0);
    check("zero_iready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // Rotation of row 1 by a single non-zero byte.
    send(32'h0, 32'h00530000, 32'h0, 32'h0, 1'b0);
    wait_done("rot1");
    check_rows("rot1", 32'h63636363, 32'hed636363, 32'h63636363, 32'h63636363);
    drain();

    // Distinct bytes in every row exercise all four rotation amounts.
    send(32'h00010203, 32'h00010203, 32'h00010203, 32'h00010203, 1'b0);
    wait_done("rotall");
    check_rows("rotall", 32'h637c777b, 32'h7c777b63, 32'h777b637c, 32'h7b637c77);
    drain();

    // Reset in the middle of SUB discards the partial state.
    send(32'h19a09ae9, 32'h3df4c6f8, 32'he3e28d48, 32'hbe2b2a08, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_zero("rst_sub", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_idle_zero("rst_sub_rel", 1'b1);

    // Reset while DONE is held by backpressure.
    send(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    wait_done("pre_rst_done");
    rst_n = 1'b0;
    #1;
    check_idle_zero("rst_done", 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_done_rel_iready", 32'(in_ready), 32'd1);

`ifdef SUB_SHIFT_DECRYPT_EN
    send(32'h63636363, 32'h63636363, 32'h63636363, 32'h63636363, 1'b1);
    wait_done("dec_zero");
    check_rows("dec_zero", 32'h0, 32'h0, 32'h0, 32'h0);
    drain();
    send(32'h63636363, 32'hed636363, 32'h63636363, 32'h63636363, 1'b1);
    wait_done("dec_rot1");
    check_rows("dec_rot1", 32'h0, 32'h00530000, 32'h0, 32'h0);
    drain();
    send(32'h0, 32'h00530000, 32'h0, 32'h0, 1'b0);
    wait_done("enc_after_dec");
    check_rows("enc_after_dec", 32'h63636363, 32'hed636363, 32'h63636363, 32'h63636363);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
